stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Multicycle FSM controller for the 8-bit stack-machine datapath: 5-bit PC, IR, MDR, 8-bit stack, A/B operand registers, 2-bit-op ALU.
- Decodes IR[7:5]. Drives every datapath control strobe for fetch, operand pop, ALU result push, memory push/pop and jumps.
- Uses a `run` gate so a testbench or top level can start and pause execution at instruction boundaries.

Parameters:
- PERF_W, 16, width of the retired-instruction counter (used only when CTRL_PERF_CNT_EN is defined).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- run  in  1  when high, FETCH may start a new instruction.
- opcode  in  3  IR[7:5] from the datapath.
- tos  in  8  current top of stack, used by JZ.
- addrSrc  out  1  memory address select: 0 = PC, 1 = IR[4:0].
- mem_write  out  1  memory write strobe; write data is the stack output.
- load_a, load_b  out  1 each  load A or B from the stack output.
- push, pop  out  1 each  stack strobes.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- stack_src  out  1  stack input select: 0 = ALU, 1 = MDR.
- mdr_en  out  1  MDR load enable.
- jump  out  1  PC source select: 0 = PC+1, 1 = IR[4:0].
- alu_control  out  2  ALU operation select.
- instr_done  out  1  one-cycle pulse in the last state of each instruction.
- busy  out  1  high in every state except FETCH while it waits for run.
- perf_cnt  out  PERF_W  retired-instruction count (exists only with CTRL_PERF_CNT_EN).

Behaviour:
- Opcode map: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr.
- All outputs are Moore-decoded from the state register, except jump/pc_write in JZ, which also depend on tos. Any strobe not listed for a state is 0.
- Reset (rst==0 at an edge): state goes to FETCH and perf_cnt to 0; all strobes are 0 in that cycle. A reset mid-instruction abandons the instruction with no further strobes.
- FETCH:
  - run==1: addrSrc=0, ir_write=1, pc_write=1, jump=0, then go to DECODE.
  - run==0: all strobes 0, busy=0, stay in FETCH.
- DECODE: no strobes. Next state:
  - 000/001/010 go to POP_A.
  - 011 goes to POP_A.
  - 100 goes to MEM_RD.
  - 101 goes to MEM_WR.
  - 110 goes to JMP.
  - 111 goes to JZ.
- POP_A: load_a=1, pop=1. Next is ALU_PUSH if opcode==011, otherwise POP_B.
- POP_B: load_b=1, pop=1. Next is ALU_PUSH.
- ALU_PUSH: alu_control=opcode[1:0], stack_src=0, push=1, instr_done=1. Next is FETCH.
- MEM_RD: addrSrc=1, mdr_en=1. Next is PUSH_MDR.
- PUSH_MDR: stack_src=1, push=1, instr_done=1. Next is FETCH.
- MEM_WR: addrSrc=1, mem_write=1, pop=1, instr_done=1. Next is FETCH.
- JMP: jump=1, pc_write=1, instr_done=1. Next is FETCH.
- JZ: jump=1 and pc_write=1 only if tos==8'h00, otherwise both 0. The stack is not popped. instr_done=1. Next is FETCH.
- alu_control is 2'b00 in every state other than ALU_PUSH.
- Latency in cycles, FETCH included:
  - ADD/SUB/AND: 5.
  - NOT: 4.
  - PUSH: 4.
  - POP, JMP, JZ: 3.
- run is sampled only in FETCH. Dropping run mid-instruction does not stall; the instruction completes.
- The state register never holds an unused encoding; the default case goes to FETCH.
- Stack full/empty is not checked; the stack block owns that behaviour.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined: the perf_cnt port exists. It increments by 1, wrapping modulo 2^PERF_W, on every edge where instr_done==1. It clears on reset.
- Undefined: no perf_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then rst=1, run=0 → all strobes 0, busy=0, state held in FETCH for 10 cycles.
- ADD: run=1, opcode=000 → strobe sequence per cycle:
  - cycle 1: ir_write+pc_write.
  - cycle 2: none.
  - cycle 3: load_a+pop.
  - cycle 4: load_b+pop.
  - cycle 5: push with alu_control=00, stack_src=0, instr_done=1.
  - then back in FETCH.
- NOT: opcode=011 → POP_B is skipped; the push in cycle 4 has alu_control=11.
- PUSH then POP:
  - opcode=100 → addrSrc=1+mdr_en, then push with stack_src=1.
  - opcode=101 → cycle 3 has addrSrc=1, mem_write=1, pop=1 together.
- JZ:
  - tos=8'h00 → cycle 3 has jump=1, pc_write=1.
  - tos=8'h05 → cycle 3 has jump=0, pc_write=0, and instr_done=1 in both cases.
- Reset mid-op and counter:
  - assert rst=0 during POP_B → the next cycle is FETCH with no push.
  - with CTRL_PERF_CNT_EN and PERF_W=4, run 17 JMPs → perf_cnt=1 (wrap).

Source files
------------

// File: rtl/stack_ctrl_if.sv
// Control bundle between the stack-machine controller and its datapath.
// Optional retired-instruction counter in stack_ctrl is enabled by CTRL_PERF_CNT_EN.
interface stack_ctrl_if;
  logic       run;
  logic [2:0] opcode;
  logic [7:0] tos;

  logic       addrSrc;
  logic       mem_write;
  logic       load_a;
  logic       load_b;
  logic       push;
  logic       pop;
  logic       pc_write;
  logic       ir_write;
  logic       stack_src;
  logic       mdr_en;
  logic       jump;
  logic [1:0] alu_control;
  logic       instr_done;
  logic       busy;

  // Controller side: consumes run/IR/TOS, drives every datapath strobe
  modport master (
    input  run, opcode, tos,
    output addrSrc, mem_write, load_a, load_b, push, pop, pc_write,
           ir_write, stack_src, mdr_en, jump, alu_control, instr_done, busy
  );

  // Datapath side
  modport slave (
    output run, opcode, tos,
    input  addrSrc, mem_write, load_a, load_b, push, pop, pc_write,
           ir_write, stack_src, mdr_en, jump, alu_control, instr_done, busy
  );
endinterface

// File: rtl/stack_ctrl.sv
// Multicycle FSM controller for the 8-bit stack-machine datapath.
// Define CTRL_PERF_CNT_EN to add the PERF_W-bit retired-instruction counter port perf_cnt.
module stack_ctrl
`ifdef CTRL_PERF_CNT_EN
  #(parameter int unsigned PERF_W = 16)
`endif
(
  input  logic             clk,
  input  logic             rst,
  stack_ctrl_if.master     bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_cnt
`endif
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_POP_A    = 4'd2,
    S_POP_B    = 4'd3,
    S_ALU_PUSH = 4'd4,
    S_MEM_RD   = 4'd5,
    S_PUSH_MDR = 4'd6,
    S_MEM_WR   = 4'd7,
    S_JMP      = 4'd8,
    S_JZ       = 4'd9
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  state_t state;
  state_t state_nxt;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore strobe decode; JZ alone looks at tos
  always_comb begin
    state_nxt            = S_FETCH;
    bus.addrSrc          = 1'b0;
    bus.mem_write        = 1'b0;
    bus.load_a           = 1'b0;
    bus.load_b           = 1'b0;
    bus.push             = 1'b0;
    bus.pop              = 1'b0;
    bus.pc_write         = 1'b0;
    bus.ir_write         = 1'b0;
    bus.stack_src        = 1'b0;
    bus.mdr_en           = 1'b0;
    bus.jump             = 1'b0;
    bus.alu_control      = 2'b00;
    bus.instr_done       = 1'b0;
    bus.busy             = 1'b1;

    case (state)
      S_FETCH: begin
        if (bus.run) begin
          bus.addrSrc  = 1'b0;
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          bus.jump     = 1'b0;
          state_nxt    = S_DECODE;
        end else begin
          bus.busy  = 1'b0;
          state_nxt = S_FETCH;
        end
      end

      S_DECODE: begin
        case (bus.opcode)
          OP_ADD, OP_SUB, OP_AND: state_nxt = S_POP_A;
          OP_NOT:                 state_nxt = S_POP_A;
          OP_PUSH:                state_nxt = S_MEM_RD;
          OP_POP:                 state_nxt = S_MEM_WR;
          OP_JMP:                 state_nxt = S_JMP;
          OP_JZ:                  state_nxt = S_JZ;
          default:                state_nxt = S_FETCH;
        endcase
      end

      S_POP_A: begin
        bus.load_a = 1'b1;
        bus.pop    = 1'b1;
        state_nxt  = (bus.opcode == OP_NOT) ? S_ALU_PUSH : S_POP_B;
      end

      S_POP_B: begin
        bus.load_b = 1'b1;
        bus.pop    = 1'b1;
        state_nxt  = S_ALU_PUSH;
      end

      S_ALU_PUSH: begin
        bus.alu_control = bus.opcode[1:0];
        bus.stack_src   = 1'b0;
        bus.push        = 1'b1;
        bus.instr_done  = 1'b1;
        state_nxt       = S_FETCH;
      end

      S_MEM_RD: begin
        bus.addrSrc = 1'b1;
        bus.mdr_en  = 1'b1;
        state_nxt   = S_PUSH_MDR;
      end

      S_PUSH_MDR: begin
        bus.stack_src  = 1'b1;
        bus.push       = 1'b1;
        bus.instr_done = 1'b1;
        state_nxt      = S_FETCH;
      end

      S_MEM_WR: begin
        bus.addrSrc    = 1'b1;
        bus.mem_write  = 1'b1;
        bus.pop        = 1'b1;
        bus.instr_done = 1'b1;
        state_nxt      = S_FETCH;
      end

      S_JMP: begin
        bus.jump       = 1'b1;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
        state_nxt      = S_FETCH;
      end

      // Branch taken only on a zero top of stack; the stack is left intact
      S_JZ: begin
        bus.jump       = (bus.tos == 8'h00);
        bus.pc_write   = (bus.tos == 8'h00);
        bus.instr_done = 1'b1;
        state_nxt      = S_FETCH;
      end

      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    // An in-flight instruction is abandoned silently while reset is held
    if (!rst) begin
      bus.addrSrc     = 1'b0;
      bus.mem_write   = 1'b0;
      bus.load_a      = 1'b0;
      bus.load_b      = 1'b0;
      bus.push        = 1'b0;
      bus.pop         = 1'b0;
      bus.pc_write    = 1'b0;
      bus.ir_write    = 1'b0;
      bus.stack_src   = 1'b0;
      bus.mdr_en      = 1'b0;
      bus.jump        = 1'b0;
      bus.alu_control = 2'b00;
      bus.instr_done  = 1'b0;
      bus.busy        = 1'b0;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Retired-instruction counter, wraps modulo 2^PERF_W
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if (bus.instr_done) begin
      perf_cnt <= perf_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed plan steps plus random instruction streams
// against a per-instruction strobe timeline model; covers perf_cnt when CTRL_PERF_CNT_EN is set.
module tb_stack_ctrl;

`ifdef CTRL_PERF_CNT_EN
  localparam int unsigned PERF_W = 4;
  logic [PERF_W-1:0] perf_cnt;
  int unsigned       perf_model;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stack_ctrl_if bus ();

`ifdef CTRL_PERF_CNT_EN
  stack_ctrl #(.PERF_W(PERF_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .perf_cnt (perf_cnt)
  );
`else
  stack_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
  );
`endif

  // {addrSrc, mem_write, load_a, load_b, push, pop, pc_write, ir_write,
  //  stack_src, mdr_en, jump, alu_control[1:0], instr_done, busy}
  logic [14:0] obs;
  assign obs = {bus.addrSrc, bus.mem_write, bus.load_a, bus.load_b, bus.push, bus.pop,
                bus.pc_write, bus.ir_write, bus.stack_src, bus.mdr_en, bus.jump,
                bus.alu_control, bus.instr_done, bus.busy};

  function automatic logic [14:0] mk(input logic addr, input logic memw, input logic la,
                                      input logic lb, input logic psh, input logic pp,
                                      input logic pcw, input logic irw, input logic ssrc,
                                      input logic mdr, input logic jmp, input logic [1:0] alu,
                                      input logic done, input logic bsy);
    return {addr, memw, la, lb, psh, pp, pcw, irw, ssrc, mdr, jmp, alu, done, bsy};
  endfunction

  // Instruction length in cycles, FETCH included
  function automatic int lat(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd2: return 5;
      3'd3, 3'd4:       return 4;
      default:          return 3;
    endcase
  endfunction

  // Expected strobes in cycle k of an instruction
  function automatic logic [14:0] exp_vec(input logic [2:0] op, input logic [7:0] t, input int k);
    logic z;
    z = (t == 8'h00);
    if (k == 0) return mk(0,0,0,0,0,0,1,1,0,0,0,2'b00,0,1);
    if (k == 1) return mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,0,1);
    case (op)
      3'd0, 3'd1, 3'd2: begin
        if (k == 2) return mk(0,0,1,0,0,1,0,0,0,0,0,2'b00,0,1);
        if (k == 3) return mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,0,1);
        return mk(0,0,0,0,1,0,0,0,0,0,0,op[1:0],1,1);
      end
      3'd3: begin
        if (k == 2) return mk(0,0,1,0,0,1,0,0,0,0,0,2'b00,0,1);
        return mk(0,0,0,0,1,0,0,0,0,0,0,2'b11,1,1);
      end
      3'd4: begin
        if (k == 2) return mk(1,0,0,0,0,0,0,0,0,1,0,2'b00,0,1);
        return mk(0,0,0,0,1,0,0,0,1,0,0,2'b00,1,1);
      end
      3'd5:    return mk(1,1,0,0,0,1,0,0,0,0,0,2'b00,1,1);
      3'd6:    return mk(0,0,0,0,0,0,1,0,0,0,1,2'b00,1,1);
      default: return mk(0,0,0,0,0,0,z,0,0,0,z,2'b00,1,1);
    endcase
  endfunction

  task automatic check(input string tag, input logic [14:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic check_perf(input string tag);
    logic [PERF_W-1:0] e;
    e = PERF_W'(perf_model);
    total++;
    assert (perf_cnt === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, perf_cnt, e);
    end
  endtask
`endif

  // One cycle: inputs already driven just after posedge, check on negedge
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.run = 1'b0;
      @(negedge clk);
      check(tag, 15'd0);
      @(posedge clk); #1;
    end
  endtask

  // run may wander after FETCH; the instruction must still complete
  task automatic run_instr(input logic [2:0] op, input logic [7:0] t);
    int n;
    n = lat(op);
    for (int k = 0; k < n; k++) begin
      bus.opcode = op;
      bus.tos    = t;
      bus.run    = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("op%0d_tos%0h_c%0d", op, t, k), exp_vec(op, t, k));
      @(posedge clk); #1;
    end
`ifdef CTRL_PERF_CNT_EN
    perf_model = (perf_model + 1) % (1 << PERF_W);
    check_perf($sformatf("perf_after_op%0d", op));
`endif
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] t;

    bus.run    = 1'b1;
    bus.opcode = 3'd0;
    bus.tos    = 8'h00;
    rst        = 1'b0;
`ifdef CTRL_PERF_CNT_EN
    perf_model = 0;
`endif
    @(posedge clk); #1;

    // Reset held two cycles with run high: nothing may move
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_hold", 15'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    idle(10, "idle_run0");
`ifdef CTRL_PERF_CNT_EN
    check_perf("perf_reset");
`endif

    // Directed plan steps
    run_instr(3'd0, 8'h12);
    idle(1, "gap");
    run_instr(3'd3, 8'h34);
    run_instr(3'd4, 8'h00);
    run_instr(3'd5, 8'h77);
    run_instr(3'd7, 8'h00);
    run_instr(3'd7, 8'h05);
    run_instr(3'd1, 8'h01);
    run_instr(3'd2, 8'hff);
    run_instr(3'd6, 8'h00);

    // Reset during POP_B of an ADD: no push may follow
    for (int k = 0; k < 3; k++) begin
      bus.opcode = 3'd0;
      bus.run    = 1'b1;
      @(negedge clk);
      check($sformatf("abort_c%0d", k), exp_vec(3'd0, 8'h00, k));
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_reset", 15'd0);
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef CTRL_PERF_CNT_EN
    perf_model = 0;
    check_perf("perf_after_abort");
`endif
    idle(2, "abort_fetch");
    run_instr(3'd6, 8'h10);

    // Random instruction stream with idle gaps
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      t  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_instr(op, t);
      idle(int'($urandom_range(0, 2)), "rand_gap");
    end

`ifdef CTRL_PERF_CNT_EN
    // Counter wrap: 17 JMPs from reset on a 4-bit counter leaves 1
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    perf_model = 0;
    for (int i = 0; i < 17; i++) run_instr(3'd6, 8'h00);
    total++;
    assert (perf_cnt === 4'd1) else begin
      bad++;
      $error("FAIL perf_wrap observed=%0d expected=1", perf_cnt);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
